light_driver: RTL and testbench

- Lamp-side consumer of the 2-bit light code produced by the traffic-light state machine. It decodes the code into individual car and pedestrian lamp drives.
- Dims the lamps with PWM and flashes the pedestrian "walk" lamp near the end of the pedestrian phase.
- Independently checks every phase transition for legality and minimum yellow duration. On a violation it latches a safety fault and forces flashing yellow until an explicit clear.
- Sits between the controller and the board lamp pins, sharing the controller's blink timebase.

---
 rtl/light_driver_if.sv | 29 ++
 rtl/light_driver.sv | 146 ++++++++++++++
 tb/tb_light_driver.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/light_driver_if.sv
// Controller-to-lamp signal bundle for light_driver: timebase, light code,
// brightness and clear request in; lamp drives, fault flag and phase age out.
interface light_driver_if #(
    parameter int C_PWM_BITS = 8
);
    logic                  blink;
    logic [1:0]            inLight;
    logic [C_PWM_BITS-1:0] inBrightness;
    logic                  inClearFault;
    logic                  outCarRed;
    logic                  outCarYellow;
    logic                  outCarGreen;
    logic                  outPedWalk;
    logic                  outPedStop;
    logic                  outFault;
    logic [7:0]            outPhaseBlinks;

    modport master (
        output blink, inLight, inBrightness, inClearFault,
        input  outCarRed, outCarYellow, outCarGreen, outPedWalk, outPedStop,
        input  outFault, outPhaseBlinks
    );

    modport slave (
        input  blink, inLight, inBrightness, inClearFault,
        output outCarRed, outCarYellow, outCarGreen, outPedWalk, outPedStop,
        output outFault, outPhaseBlinks
    );
endinterface

// File: rtl/light_driver.sv
// Lamp decoder with PWM dimming, walk-lamp flashing and an independent
// phase-transition monitor that latches a fault and forces flashing yellow.
module light_driver #(
    parameter int C_PWM_BITS   = 8,
    parameter int C_MIN_YELLOW = 20,
    parameter int C_PED_STEADY = 50,
    parameter int C_RECOVER    = 10
) (
    input logic           clk,
    input logic           rst,
    light_driver_if.slave bus
);

    typedef enum logic [1:0] {
        sRun     = 2'b00,
        sFault   = 2'b01,
        sRecover = 2'b10
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic                  blink_r;
    logic [1:0]            light_r;
    logic [7:0]            count_r;
    logic                  flash_r;
    logic [C_PWM_BITS-1:0] pwm_r;
    logic [4:0]            lamp_r;
    logic                  fault_r;

    logic                  tick_s;
    logic                  change_s;
    logic                  legal_s;
    logic                  fault_entry_s;
    logic                  recover_entry_s;
    logic                  pwm_on_s;
    logic                  walk_s;
    logic [4:0]            lamp_s;

    assign tick_s          = bus.blink & ~blink_r;
    assign change_s        = (bus.inLight != light_r);
    assign pwm_on_s        = (&bus.inBrightness) | (pwm_r < bus.inBrightness);
    assign fault_entry_s   = (state_next_s == sFault) && (state_r != sFault);
    assign recover_entry_s = (state_next_s == sRecover) && (state_r != sRecover);
    assign walk_s          = (count_r < 8'(C_PED_STEADY)) ? 1'b1 : flash_r;

    // Transition legality; leaving yellow also needs the minimum dwell.
    always_comb begin
        legal_s = 1'b0;
        case ({light_r, bus.inLight})
            4'b00_01, 4'b00_11, 4'b01_10, 4'b11_00: legal_s = 1'b1;
            4'b10_00: legal_s = (count_r >= 8'(C_MIN_YELLOW));
            default:  legal_s = 1'b0;
        endcase
    end

    // Monitor next state; an unknown encoding is treated as a fault.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            sRun: begin
                if (change_s && !legal_s) state_next_s = sFault;
                else                      state_next_s = sRun;
            end
            sFault: begin
                if (bus.inClearFault && (bus.inLight == 2'b00)) state_next_s = sRecover;
                else                                            state_next_s = sFault;
            end
            sRecover: begin
                if (bus.inLight != 2'b00)                 state_next_s = sFault;
                else if (count_r == 8'(C_RECOVER))        state_next_s = sRun;
                else                                      state_next_s = sRecover;
            end
            default: state_next_s = sFault;
        endcase
    end

    // Lamp decode, bit order {car red, car yellow, car green, walk, stop}.
    always_comb begin
        lamp_s = 5'b00000;
        case (state_r)
            sRun: begin
                case (light_r)
                    2'b00:   lamp_s = 5'b10001;
                    2'b01:   lamp_s = 5'b00101;
                    2'b10:   lamp_s = 5'b01001;
                    2'b11:   lamp_s = {1'b1, 2'b00, walk_s, 1'b0};
                    default: lamp_s = 5'b10001;
                endcase
            end
            sFault:   lamp_s = {1'b0, flash_r, 2'b00, 1'b1};
            sRecover: lamp_s = 5'b10001;
            default:  lamp_s = {1'b0, flash_r, 2'b00, 1'b1};
        endcase
    end

    // Monitor state, sampled code, edge detector and PWM ramp.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= sRun;
            light_r <= 2'b00;
            blink_r <= 1'b0;
            pwm_r   <= '0;
        end else begin
            state_r <= state_next_s;
            light_r <= bus.inLight;
            blink_r <= bus.blink;
            pwm_r   <= pwm_r + 1'b1;
        end
    end

    // Phase age; a clear beats a coincident tick.
    always_ff @(posedge clk) begin
        if (rst)                                 count_r <= 8'd0;
        else if (change_s || recover_entry_s)    count_r <= 8'd0;
        else if (tick_s && (count_r != 8'hFF))   count_r <= count_r + 8'd1;
        else                                     count_r <= count_r;
    end

    // Flash phase restarts lit on every change and fault entry.
    always_ff @(posedge clk) begin
        if (rst)                            flash_r <= 1'b1;
        else if (change_s || fault_entry_s) flash_r <= 1'b1;
        else if (tick_s)                    flash_r <= ~flash_r;
        else                                flash_r <= flash_r;
    end

    // Registered outputs; the fault flag is never dimmed.
    always_ff @(posedge clk) begin
        if (rst) begin
            lamp_r  <= 5'b00000;
            fault_r <= 1'b0;
        end else begin
            lamp_r  <= lamp_s & {5{pwm_on_s}};
            fault_r <= (state_next_s == sFault);
        end
    end

    assign bus.outCarRed      = lamp_r[4];
    assign bus.outCarYellow   = lamp_r[3];
    assign bus.outCarGreen    = lamp_r[2];
    assign bus.outPedWalk     = lamp_r[1];
    assign bus.outPedStop     = lamp_r[0];
    assign bus.outFault       = fault_r;
    assign bus.outPhaseBlinks = count_r;

endmodule

// File: tb/tb_light_driver.sv
// Directed bench for light_driver: phase-sequence vector table plus
// hand-written walk flashing, saturation, PWM and reset corner cases.
module tb_light_driver;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    light_driver_if #(.C_PWM_BITS(8)) bus ();

    light_driver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0] light;
        logic       clr;
        int         nt;
        logic [4:0] lamps;
        logic       fault;
        logic [7:0] blk0;
        logic [7:0] blk;
    } vec_t;

    vec_t tv[20];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic [1:0] light, input logic clr, input int nt,
                                input logic [4:0] lamps, input logic fault,
                                input logic [7:0] blk0, input logic [7:0] blk);
        vec_t v;
        v.light = light; v.clr = clr; v.nt = nt; v.lamps = lamps;
        v.fault = fault; v.blk0 = blk0; v.blk = blk;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.blink = 1'b1;
        cyc();
        bus.blink = 1'b0;
        cyc();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] lamps();
        return {bus.outCarRed, bus.outCarYellow, bus.outCarGreen, bus.outPedWalk, bus.outPedStop};
    endfunction

    initial begin
        int on_cnt;
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.blink = 1'b0;
        bus.inLight = 2'b00;
        bus.inBrightness = 8'hFF;
        bus.inClearFault = 1'b0;

        // lamps = {red, yellow, green, walk, stop}
        tv[0]  = mk(2'b00, 1'b0, 0,  5'b10001, 1'b0, 8'd0, 8'd0);
        tv[1]  = mk(2'b01, 1'b0, 3,  5'b00101, 1'b0, 8'd0, 8'd3);
        tv[2]  = mk(2'b10, 1'b0, 20, 5'b01001, 1'b0, 8'd0, 8'd20);
        tv[3]  = mk(2'b00, 1'b0, 2,  5'b10001, 1'b0, 8'd0, 8'd2);
        tv[4]  = mk(2'b11, 1'b0, 5,  5'b10010, 1'b0, 8'd0, 8'd5);
        tv[5]  = mk(2'b00, 1'b0, 1,  5'b10001, 1'b0, 8'd0, 8'd1);
        tv[6]  = mk(2'b01, 1'b0, 0,  5'b00101, 1'b0, 8'd0, 8'd0);
        tv[7]  = mk(2'b10, 1'b0, 5,  5'b01001, 1'b0, 8'd0, 8'd5);
        tv[8]  = mk(2'b00, 1'b0, 0,  5'b01001, 1'b1, 8'd0, 8'd0);
        tv[9]  = mk(2'b00, 1'b0, 1,  5'b00001, 1'b1, 8'd0, 8'd1);
        tv[10] = mk(2'b00, 1'b0, 1,  5'b01001, 1'b1, 8'd1, 8'd2);
        tv[11] = mk(2'b01, 1'b1, 0,  5'b01001, 1'b1, 8'd0, 8'd0);
        tv[12] = mk(2'b00, 1'b1, 0,  5'b10001, 1'b0, 8'd0, 8'd0);
        tv[13] = mk(2'b00, 1'b0, 9,  5'b10001, 1'b0, 8'd0, 8'd9);
        tv[14] = mk(2'b00, 1'b0, 1,  5'b10001, 1'b0, 8'd9, 8'd10);
        tv[15] = mk(2'b01, 1'b0, 0,  5'b00101, 1'b0, 8'd0, 8'd0);
        tv[16] = mk(2'b00, 1'b0, 0,  5'b01001, 1'b1, 8'd0, 8'd0);
        tv[17] = mk(2'b00, 1'b1, 3,  5'b10001, 1'b0, 8'd0, 8'd3);
        tv[18] = mk(2'b01, 1'b0, 0,  5'b01001, 1'b1, 8'd0, 8'd0);
        tv[19] = mk(2'b00, 1'b1, 10, 5'b10001, 1'b0, 8'd0, 8'd10);

        cyc();
        cyc();
        chk("reset_lamps", 32'(lamps()), 32'd0);
        chk("reset_fault", 32'(bus.outFault), 32'd0);
        chk("reset_blinks", 32'(bus.outPhaseBlinks), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            bus.inLight = tv[i].light;
            bus.inClearFault = tv[i].clr;
            cyc();
            chk($sformatf("v%0d_fault_k", i), 32'(bus.outFault), 32'(tv[i].fault));
            chk($sformatf("v%0d_blinks_k", i), 32'(bus.outPhaseBlinks), 32'(tv[i].blk0));
            for (int t = 0; t < tv[i].nt; t++) tick();
            cyc();
            chk($sformatf("v%0d_lamps", i), 32'(lamps()), 32'(tv[i].lamps));
            chk($sformatf("v%0d_fault", i), 32'(bus.outFault), 32'(tv[i].fault));
            chk($sformatf("v%0d_blinks", i), 32'(bus.outPhaseBlinks), 32'(tv[i].blk));
        end

        // Pedestrian phase: walk steady to 50 ticks, then follows the flash.
        bus.inClearFault = 1'b0;
        bus.inLight = 2'b11;
        cyc();
        chk("ped_blinks_k", 32'(bus.outPhaseBlinks), 32'd0);
        for (int t = 0; t < 49; t++) tick();
        chk("ped_walk_49", 32'(lamps()), 32'b10010);
        tick();
        chk("ped_walk_50", 32'(lamps()), 32'b10010);
        tick();
        chk("ped_walk_51", 32'(lamps()), 32'b10000);
        tick();
        chk("ped_walk_52", 32'(lamps()), 32'b10010);
        for (int t = 0; t < 8; t++) tick();
        chk("ped_blinks_60", 32'(bus.outPhaseBlinks), 32'd60);
        bus.inLight = 2'b00;
        cyc();
        cyc();
        chk("ped_exit_fault", 32'(bus.outFault), 32'd0);
        chk("ped_exit_lamps", 32'(lamps()), 32'b10001);

        // Phase age saturates at 255.
        for (int t = 0; t < 255; t++) tick();
        chk("sat_255", 32'(bus.outPhaseBlinks), 32'd255);
        tick();
        chk("sat_hold", 32'(bus.outPhaseBlinks), 32'd255);

        // Quarter duty in Red.
        bus.inBrightness = 8'd64;
        cyc();
        on_cnt = 0;
        for (int c = 0; c < 256; c++) begin
            cyc();
            on_cnt += int'(bus.outCarRed);
        end
        chk("pwm_64", 32'(on_cnt), 32'd64);

        // Zero duty while faulted (00 -> 10 is illegal).
        bus.inBrightness = 8'd0;
        bus.inLight = 2'b10;
        cyc();
        chk("dark_fault_k", 32'(bus.outFault), 32'd1);
        on_cnt = 0;
        for (int c = 0; c < 256; c++) begin
            cyc();
            if (lamps() != 5'b00000) on_cnt++;
            if (c == 100) tick();
        end
        chk("dark_lamps", 32'(on_cnt), 32'd0);
        chk("dark_fault", 32'(bus.outFault), 32'd1);

        // Reset while faulted: nothing retained.
        bus.inBrightness = 8'hFF;
        bus.inLight = 2'b00;
        rst = 1'b1;
        cyc();
        chk("rst_flt_lamps", 32'(lamps()), 32'd0);
        chk("rst_flt_fault", 32'(bus.outFault), 32'd0);
        chk("rst_flt_blinks", 32'(bus.outPhaseBlinks), 32'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_lamps", 32'(lamps()), 32'b10001);
        chk("post_rst_fault", 32'(bus.outFault), 32'd0);

        // Tick coinciding with a phase change: the clear wins.
        tick();
        tick();
        chk("pre_coinc_blinks", 32'(bus.outPhaseBlinks), 32'd2);
        bus.inLight = 2'b01;
        bus.blink = 1'b1;
        cyc();
        chk("coinc_blinks_k", 32'(bus.outPhaseBlinks), 32'd0);
        bus.blink = 1'b0;
        cyc();
        chk("coinc_blinks", 32'(bus.outPhaseBlinks), 32'd0);
        chk("coinc_lamps", 32'(lamps()), 32'b00101);
        chk("coinc_fault", 32'(bus.outFault), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
